accumulator_writeback_unit: RTL



---
 rtl/accumulator_writeback_unit_pkg.sv | 16 +
 rtl/accumulator_writeback_unit_if.sv | 34 +++
 rtl/accumulator_writeback_unit_requant_lane.sv | 35 +++
 rtl/accumulator_writeback_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/accumulator_writeback_unit_pkg.sv
// Shared widths and the writeback FSM state type for the accumulator
// writeback path.
package tpu_package;
  localparam int MUL_SIZE   = 4;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 8;
  localparam int ACC_ADDR_W = 10;
  localparam int UB_ADDR_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_t;
endpackage

// File: rtl/accumulator_writeback_unit_if.sv
// Accumulator read port and unified-buffer write port seen by the writeback unit.
//
// Handshake rules:
//   Accumulator side: read_accumulator_o is a single-cycle strobe with
//   accumulator_addr_rd_o; accumulator_data_i is valid exactly one cycle later.
//   There is no ready; the writer guarantees it has room for every read it issues.
//   Unified-buffer side: ub_wr_grant_i acts as ready and a pending FIFO head acts
//   as valid. unified_buffer_write_en_o = valid && ready, so a write only happens
//   in a granted cycle, and address and data are meaningful only while it is high.
interface accumulator_writeback_unit_if
  import tpu_package::*;
#(
  parameter int MUL_SIZE = tpu_package::MUL_SIZE
);
  logic                      read_accumulator_o;
  logic [ACC_ADDR_W-1:0]     accumulator_addr_rd_o;
  logic [MUL_SIZE*ACC_W-1:0] accumulator_data_i;
  logic                      ub_wr_grant_i;
  logic                      unified_buffer_write_en_o;
  logic [UB_ADDR_W-1:0]      unified_buffer_addr_wr_o;
  logic [MUL_SIZE*OUT_W-1:0] unified_buffer_data_o;

  modport master (
    output read_accumulator_o, accumulator_addr_rd_o,
    output unified_buffer_write_en_o, unified_buffer_addr_wr_o, unified_buffer_data_o,
    input  accumulator_data_i, ub_wr_grant_i
  );

  modport slave (
    input  read_accumulator_o, accumulator_addr_rd_o,
    input  unified_buffer_write_en_o, unified_buffer_addr_wr_o, unified_buffer_data_o,
    output accumulator_data_i, ub_wr_grant_i
  );
endinterface

// File: rtl/accumulator_writeback_unit_requant_lane.sv
// One lane of requantization: round-half-up arithmetic right shift,
// optional ReLU, then saturation to the signed output range.
module requant_lane
  import tpu_package::*;
(
  input  logic [ACC_W-1:0] acc_value,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  output logic [OUT_W-1:0] out_value
);
  localparam int W = ACC_W + 1;

  // One extra bit so adding the rounding constant can never overflow.
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = ~MAX_V;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] shifted;

  // Round, shift, clamp negatives when ReLU is on, then saturate.
  always_comb begin
    ext       = $signed({acc_value[ACC_W-1], acc_value});
    rnd       = '0;
    if (shift != 5'd0) rnd = $signed(ONE << (shift - 5'd1));
    sum       = ext + rnd;
    shifted   = sum >>> shift;
    if (relu_en && shifted[W-1]) shifted = '0;
    out_value = shifted[OUT_W-1:0];
    if (shifted > MAX_V)      out_value = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V) out_value = MIN_V[OUT_W-1:0];
  end
endmodule

// File: rtl/accumulator_writeback_unit.sv
// Drains accumulator rows, requantizes each lane to 8 bits and writes the
// rows into the unified buffer in read order through a 2-entry FIFO.
module accumulator_writeback_unit
  import tpu_package::*;
#(
  parameter int MUL_SIZE = tpu_package::MUL_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [9:0]            rows_i,
  input  logic [ACC_ADDR_W-1:0] acc_base_addr_i,
  input  logic [UB_ADDR_W-1:0]  ub_base_addr_i,
  input  logic [4:0]            shift_i,
  input  logic                  relu_en_i,
  accumulator_writeback_unit_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output wb_state_t             state_o
);
  localparam int ROW_W = MUL_SIZE * OUT_W;

  wb_state_t             state_q, state_d;
  logic [9:0]            rem_q;
  logic [ACC_ADDR_W-1:0] acc_addr_q;
  logic [UB_ADDR_W-1:0]  ub_addr_q;
  logic [4:0]            shift_q;
  logic                  relu_q;
  logic                  inflight_q;

  logic [UB_ADDR_W-1:0]  fifo_addr [2];
  logic [ROW_W-1:0]      fifo_row  [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_count;

  logic [ROW_W-1:0]      req_row;
  logic                  push, pop, rd_issue;
  logic [2:0]            occupancy;

  // Returning data is pushed in its arrival cycle; a granted non-empty FIFO pops.
  assign push      = inflight_q;
  assign pop       = (fifo_count != 2'd0) && bus.ub_wr_grant_i;
  // Entries that will be held next cycle; a new read is allowed only if its
  // data is guaranteed a free slot when it returns.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue  = (state_q == DRAIN) && (occupancy < 3'd2);

  for (genvar g = 0; g < MUL_SIZE; g++) begin : g_lane
    requant_lane u_lane (
      .acc_value (bus.accumulator_data_i[g*ACC_W +: ACC_W]),
      .shift     (shift_q),
      .relu_en   (relu_q),
      .out_value (req_row[g*OUT_W +: OUT_W])
    );
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: drain until the last read, flush until nothing is left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (rows_i == 10'd0) ? DONE : DRAIN;
      DRAIN: if (rd_issue && rem_q == 10'd1) state_d = FLUSH;
      FLUSH: if (!inflight_q && fifo_count == {1'b0, pop}) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job parameters latch at start; read/write counters advance per read/push.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rem_q      <= '0;
      acc_addr_q <= '0;
      ub_addr_q  <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      if (state_q == IDLE && start_i) begin
        rem_q      <= rows_i;
        acc_addr_q <= acc_base_addr_i;
        ub_addr_q  <= ub_base_addr_i;
        shift_q    <= shift_i;
        relu_q     <= relu_en_i;
      end else begin
        if (rd_issue) begin
          rem_q      <= rem_q - 10'd1;
          acc_addr_q <= acc_addr_q + 1'b1;
        end
        if (push) ub_addr_q <= ub_addr_q + 1'b1;
      end
    end
  end

  // Two-entry FIFO of {write address, requantized row}.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_row[i]  <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr_q] <= ub_addr_q;
        fifo_row[wr_ptr_q]  <= req_row;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.read_accumulator_o        = rd_issue;
  assign bus.accumulator_addr_rd_o     = acc_addr_q;
  assign bus.unified_buffer_write_en_o = pop;
  assign bus.unified_buffer_addr_wr_o  = fifo_addr[rd_ptr_q];
  assign bus.unified_buffer_data_o     = fifo_row[rd_ptr_q];
  assign busy_o                        = (state_q != IDLE);
  assign done_o                        = (state_q == DONE);
  assign state_o                       = state_q;
endmodule
